// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit:
// width codes, FSM encoding and lane merge / extend helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } lsu_state_e;

  function automatic logic f3_legal(
    input logic [2:0] f3
  );
    return (f3 == F3_B) || (f3 == F3_H) ||
           (f3 == F3_W) || (f3 == F3_BU) ||
           (f3 == F3_HU);
  endfunction

  function automatic logic [31:0] lane_merge(
    input logic [31:0] w,
    input logic [31:0] d,
    input logic [2:0]  f3,
    input logic [1:0]  off
  );
    logic [31:0] r;
    r = w;
    if (f3[1:0] == 2'b01)
      r[{off[1], 4'b0000} +: 16] = d[15:0];
    else
      r[{off, 3'b000} +: 8] = d[7:0];
    return r;
  endfunction

  function automatic logic [31:0] ld_extend(
    input logic [31:0] w,
    input logic [2:0]  f3,
    input logic [1:0]  off
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    r = '0;
    unique case (1'b1)
      (f3 == F3_B):  r = {{24{b[7]}}, b};
      (f3 == F3_BU): r = {24'h0, b};
      (f3 == F3_H):  r = {{16{h[15]}}, h};
      (f3 == F3_HU): r = {16'h0, h};
      (f3 == F3_W):  r = w;
      default:       r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data formatter: picks the addressed byte/half out of the
// memory word and sign/zero-extends it for writeback.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] mem_rd,
  input  logic [2:0]  f3,
  input  logic [1:0]  off,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = ld_extend(mem_rd, f3, off);
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage LSU: word memory access, sub-word store RMW, load align.
// Optional request checking enabled by defining LSU_ERR_CHECK_EN.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        err,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  lsu_state_e  state_q, state_d;
  logic        ld_pend_q, ld_pend_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic [31:0] rmw_addr_q, rmw_addr_d;
  logic [31:0] rmw_wdata_q, rmw_wdata_d;
  logic [2:0]  rmw_f3_q, rmw_f3_d;
  logic        bad;
  logic        ok;
  logic [31:0] ld_data;

`ifdef LSU_ERR_CHECK_EN
  logic mis_h;
  logic mis_w;
  logic oor;

  always_comb begin
    mis_h = (funct3[1:0] == 2'b01) && addr[0];
    mis_w = (funct3 == F3_W) && (addr[1:0] != 2'b00);
    oor   = {2'b00, addr[31:2]} >= 32'(MEM_WORDS);
    bad   = mis_h || mis_w || oor || !f3_legal(funct3);
  end

  assign err = req_valid && (state_q == ST_IDLE) && bad;
`else
  always_comb begin
    bad = !f3_legal(funct3);
  end

  assign err = 1'b0;
`endif

  assign ok = req_valid && (state_q == ST_IDLE) && !bad;

  always_comb begin
    state_d     = state_q;
    ld_pend_d   = 1'b0;
    ld_f3_d     = ld_f3_q;
    ld_off_d    = ld_off_q;
    rmw_addr_d  = rmw_addr_q;
    rmw_wdata_d = rmw_wdata_q;
    rmw_f3_d    = rmw_f3_q;
    mem_a       = addr;
    mem_we      = 1'b0;
    mem_wd      = wdata;
    stall       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ok && !req_we) begin
          ld_pend_d = 1'b1;
          ld_f3_d   = funct3;
          ld_off_d  = addr[1:0];
        end else if (ok && funct3 == F3_W) begin
          mem_we = 1'b1;
        end else if (ok) begin
          stall       = 1'b1;
          rmw_addr_d  = addr;
          rmw_wdata_d = wdata;
          rmw_f3_d    = funct3;
          state_d     = ST_RMW;
        end
      end
      ST_RMW: begin
        // mem_rd now holds the word read in the request cycle
        mem_a   = rmw_addr_q;
        mem_we  = 1'b1;
        mem_wd  = lane_merge(mem_rd, rmw_wdata_q,
                             rmw_f3_q, rmw_addr_q[1:0]);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ld_pend_q   <= 1'b0;
      ld_f3_q     <= '0;
      ld_off_q    <= '0;
      rmw_addr_q  <= '0;
      rmw_wdata_q <= '0;
      rmw_f3_q    <= '0;
    end else begin
      state_q     <= state_d;
      ld_pend_q   <= ld_pend_d;
      ld_f3_q     <= ld_f3_d;
      ld_off_q    <= ld_off_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_wdata_q <= rmw_wdata_d;
      rmw_f3_q    <= rmw_f3_d;
    end
  end

  lsu_load_align u_align (
    .mem_rd (mem_rd),
    .f3     (ld_f3_q),
    .off    (ld_off_q),
    .rdata  (ld_data)
  );

  assign rdata_valid = ld_pend_q;
  assign rdata       = ld_pend_q ? ld_data : 32'h0;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a sync-read word memory model.
// Inputs change 1 time unit after posedge; outputs checked at negedge.
module tb_lsu_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        err;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [64];

  int n_vec;
  int n_bad;

  lsu_mem_ctrl #(.MEM_WORDS(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .funct3      (funct3),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .err         (err),
    .mem_a       (mem_a),
    .mem_we      (mem_we),
    .mem_wd      (mem_wd),
    .mem_rd      (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // read-before-write word memory, 1-cycle read latency
  always @(posedge clk) begin
    mem_rd <= mem[mem_a[7:2]];
    if (mem_we)
      mem[mem_a[7:2]] <= mem_wd;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we,
                       input logic [2:0] f3,
                       input logic [31:0] a,
                       input logic [31:0] d);
    @(posedge clk);
    #1;
    req_valid = v;
    req_we    = we;
    funct3    = f3;
    addr      = a;
    wdata     = d;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[1] = 32'h8899AABB;
    mem[2] = 32'h11223344;
    mem[4] = 32'h55667788;
    mem_rd    = 32'h0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    funct3    = 3'b000;
    addr      = 32'h0;
    wdata     = 32'h0;

    #2;
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_we", {31'h0, mem_we}, 32'h0);
    chk("rst_rv", {31'h0, rdata_valid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back loads
    drive(1'b1, 1'b0, 3'b000, 32'h05, 32'h0);
    chk("lb_stall", {31'h0, stall}, 32'h0);
    chk("lb_we", {31'h0, mem_we}, 32'h0);
    chk("lb_rv0", {31'h0, rdata_valid}, 32'h0);
    drive(1'b1, 1'b0, 3'b101, 32'h06, 32'h0);
    chk("lb_rv", {31'h0, rdata_valid}, 32'h1);
    chk("lb_data", rdata, 32'hFFFFFFAA);
    chk("lhu_stall", {31'h0, stall}, 32'h0);
    drive(1'b1, 1'b0, 3'b010, 32'h04, 32'h0);
    chk("lhu_rv", {31'h0, rdata_valid}, 32'h1);
    chk("lhu_data", rdata, 32'h00008899);
    idle();
    chk("lw_rv", {31'h0, rdata_valid}, 32'h1);
    chk("lw_data", rdata, 32'h8899AABB);
    idle();
    chk("idle_rv", {31'h0, rdata_valid}, 32'h0);

    // SB then SH read-modify-write
    drive(1'b1, 1'b1, 3'b000, 32'h09, 32'hEE);
    chk("sb_stall", {31'h0, stall}, 32'h1);
    chk("sb_we0", {31'h0, mem_we}, 32'h0);
    drive(1'b1, 1'b1, 3'b000, 32'h09, 32'hEE);
    chk("sb_stall1", {31'h0, stall}, 32'h0);
    chk("sb_we1", {31'h0, mem_we}, 32'h1);
    chk("sb_wd", mem_wd, 32'h1122EE44);
    drive(1'b1, 1'b1, 3'b001, 32'h0A, 32'hBEEF);
    chk("sb_mem", mem[2], 32'h1122EE44);
    chk("sh_stall", {31'h0, stall}, 32'h1);
    drive(1'b1, 1'b1, 3'b001, 32'h0A, 32'hBEEF);
    chk("sh_stall1", {31'h0, stall}, 32'h0);
    chk("sh_wd", mem_wd, 32'hBEEFEE44);
    idle();
    chk("sh_mem", mem[2], 32'hBEEFEE44);
    chk("sh_idle_we", {31'h0, mem_we}, 32'h0);

    // SW then immediate LW of same word
    drive(1'b1, 1'b1, 3'b010, 32'h0C, 32'hCAFEF00D);
    chk("sw_stall", {31'h0, stall}, 32'h0);
    chk("sw_we", {31'h0, mem_we}, 32'h1);
    chk("sw_wd", mem_wd, 32'hCAFEF00D);
    drive(1'b1, 1'b0, 3'b010, 32'h0C, 32'h0);
    chk("lw2_stall", {31'h0, stall}, 32'h0);
    idle();
    chk("lw2_rv", {31'h0, rdata_valid}, 32'h1);
    chk("lw2_data", rdata, 32'hCAFEF00D);

    // reset during RMW cycle
    drive(1'b1, 1'b1, 3'b000, 32'h10, 32'h99);
    chk("rmw_rst_stall", {31'h0, stall}, 32'h1);
    drive(1'b1, 1'b1, 3'b000, 32'h10, 32'h99);
    chk("rmw_rst_we1", {31'h0, mem_we}, 32'h1);
    rst_n     = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rmw_rst_we", {31'h0, mem_we}, 32'h0);
    chk("rmw_rst_st", {31'h0, stall}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rmw_rst_mem", mem[4], 32'h55667788);
    drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    chk("post_rst_stall", {31'h0, stall}, 32'h0);
    idle();
    chk("post_rst_rv", {31'h0, rdata_valid}, 32'h1);
    chk("post_rst_data", rdata, 32'h55667788);

    // illegal funct3: no write, no load response
    drive(1'b1, 1'b0, 3'b011, 32'h04, 32'h0);
    drive(1'b1, 1'b1, 3'b111, 32'h04, 32'h12345678);
    chk("ill_ld_rv", {31'h0, rdata_valid}, 32'h0);
    chk("ill_st_we", {31'h0, mem_we}, 32'h0);
    chk("ill_st_stall", {31'h0, stall}, 32'h0);
    idle();
    chk("ill_mem", mem[1], 32'h8899AABB);

`ifdef LSU_ERR_CHECK_EN
    drive(1'b1, 1'b0, 3'b010, 32'h02, 32'h0);
    chk("e_lw_err", {31'h0, err}, 32'h1);
    drive(1'b1, 1'b1, 3'b001, 32'h03, 32'hBEEF);
    chk("e_lw_rv", {31'h0, rdata_valid}, 32'h0);
    chk("e_sh_err", {31'h0, err}, 32'h1);
    chk("e_sh_stall", {31'h0, stall}, 32'h0);
    chk("e_sh_we", {31'h0, mem_we}, 32'h0);
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    chk("e_oor_err", {31'h0, err}, 32'h1);
    idle();
    chk("e_oor_rv", {31'h0, rdata_valid}, 32'h0);
    chk("e_mem0", mem[0], 32'h0);
`else
    drive(1'b1, 1'b0, 3'b010, 32'h02, 32'h0);
    chk("n_lw_err", {31'h0, err}, 32'h0);
    drive(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    chk("n_oor_err", {31'h0, err}, 32'h0);
    chk("n_lw_data", rdata, 32'h0);
    idle();
    chk("n_idle_err", {31'h0, err}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
